// File: rtl/ring_rotate_pkg.sv
// Shared types for the ring/rotate register sequencer: command opcodes and controller states.
package ring_rotate_pkg;

    localparam logic [1:0] OP_ENC_LOAD      = 2'b00;
    localparam logic [1:0] OP_ENC_ROT_LEFT  = 2'b01;
    localparam logic [1:0] OP_ENC_ROT_RIGHT = 2'b10;
    localparam logic [1:0] OP_ENC_CLEAR     = 2'b11;

    typedef enum logic [1:0] {
        OP_LOAD      = OP_ENC_LOAD,
        OP_ROT_LEFT  = OP_ENC_ROT_LEFT,
        OP_ROT_RIGHT = OP_ENC_ROT_RIGHT,
        OP_CLEAR     = OP_ENC_CLEAR
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/ring_step_unit.sv
// One-step next-value function for a WIDTH-bit ring register (load, clear, rotate left/right).
module ring_step_unit
    import ring_rotate_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic [WIDTH-1:0] count_i,
    input  op_e              op_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] next_o
);

    always_comb begin
        next_o = count_i;
        case (op_i)
            OP_LOAD:      next_o = data_i;
            OP_CLEAR:     next_o = RESET_VAL;
            OP_ROT_LEFT:  next_o = {count_i[WIDTH-2:0], count_i[WIDTH-1]};
            OP_ROT_RIGHT: next_o = {count_i[0], count_i[WIDTH-1:1]};
            default:      next_o = count_i;
        endcase
    end

endmodule

// File: rtl/ring_rotate_sequencer.sv
// Command-driven sequencer for a ring/rotate register, one step per clock, with abort and done pulse.
// Optional macro RING_ROTATE_SEQ_ZERO_GUARD_EN rejects all-zero LOADs (done with err=1).
module ring_rotate_sequencer
    import ring_rotate_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               STEP_W    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              abort,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               aborted_q, aborted_d;
    logic [WIDTH-1:0]   step_next;
    logic               is_single;
`ifdef RING_ROTATE_SEQ_ZERO_GUARD_EN
    logic               err_q, err_d;
    logic               reject;
`endif

    ring_step_unit #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_step (
        .count_i (count_q),
        .op_i    (op_q),
        .data_i  (data_q),
        .next_o  (step_next)
    );

    assign is_single = (op_q == OP_LOAD) || (op_q == OP_CLEAR);
`ifdef RING_ROTATE_SEQ_ZERO_GUARD_EN
    // An all-zero ring can never be rotated back to a useful pattern.
    assign reject = (op_q == OP_LOAD) && (data_q == '0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_LOAD;
            data_q    <= '0;
            steps_q   <= '0;
            count_q   <= RESET_VAL;
            aborted_q <= 1'b0;
`ifdef RING_ROTATE_SEQ_ZERO_GUARD_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            steps_q   <= steps_d;
            count_q   <= count_d;
            aborted_q <= aborted_d;
`ifdef RING_ROTATE_SEQ_ZERO_GUARD_EN
            err_q     <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
            ST_EXEC: begin
                // Leave after the step that takes remaining to zero; N=0 still spends one cycle.
                if (abort || is_single || steps_q <= STEP_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d      = op_q;
        data_d    = data_q;
        steps_d   = steps_q;
        count_d   = count_q;
        aborted_d = aborted_q;
`ifdef RING_ROTATE_SEQ_ZERO_GUARD_EN
        err_d     = err_q;
`endif
        if (state_q == ST_IDLE && cmd_valid) begin
            op_d      = op_e'(cmd_op);
            data_d    = cmd_data;
            steps_d   = cmd_steps;
            aborted_d = 1'b0;
`ifdef RING_ROTATE_SEQ_ZERO_GUARD_EN
            err_d     = 1'b0;
`endif
        end else if (state_q == ST_EXEC) begin
            if (abort) begin
                aborted_d = 1'b1;
            end else if (is_single) begin
`ifdef RING_ROTATE_SEQ_ZERO_GUARD_EN
                if (reject) err_d = 1'b1;
                else        count_d = step_next;
`else
                count_d = step_next;
`endif
            end else if (steps_q != '0) begin
                count_d = step_next;
                steps_d = steps_q - STEP_W'(1);
            end
        end
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        done      = (state_q == ST_DONE);
        aborted   = done & aborted_q;
`ifdef RING_ROTATE_SEQ_ZERO_GUARD_EN
        err       = done & err_q;
`else
        err       = 1'b0;
`endif
        count     = count_q;
    end

endmodule

// File: tb/tb_ring_rotate_sequencer.sv
// Directed self-checking bench for ring_rotate_sequencer with hand-computed expectations.
module tb_ring_rotate_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] cmd_steps;
    logic       abort;
    logic [3:0] count;
    logic       busy, done, aborted, err;

    int vectors = 0;
    int fails   = 0;

    ring_rotate_sequencer #(.WIDTH(4), .STEP_W(4), .RESET_VAL(4'b0001)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
        .abort     (abort),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for exactly one accepting edge (DUT must be IDLE).
    task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [3:0] steps);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_steps = steps;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'h0;
        cmd_steps = 4'h0; abort = 1'b0;
        #23;
        chk("rst_ready_in_reset", {7'b0, cmd_ready}, 8'd1);
        reset = 1'b1;
        tick();
        chk("rst_count", {4'b0, count}, 8'b0001);
        chk("rst_flags", {4'b0, cmd_ready, busy, done, err}, 8'b1000);

        // LOAD 1010: update at T+1, one-cycle done, ready at T+2
        send(2'b00, 4'b1010, 4'd0);
        chk("load_exec", {2'b0, count, busy, cmd_ready}, {2'b0, 4'b0001, 1'b1, 1'b0});
        tick();
        chk("load_done", {2'b0, count, done, aborted}, {2'b0, 4'b1010, 1'b1, 1'b0});
        chk("load_done_ready", {7'b0, cmd_ready}, 8'd0);
        tick();
        chk("load_idle", {5'b0, done, cmd_ready, busy}, 8'b010);

        // ROT_LEFT 3 from 0001
        send(2'b00, 4'b0001, 4'd0); tick(); tick();
        send(2'b01, 4'b0000, 4'd3);
        tick(); chk("rl_s1", {3'b0, count, done}, {3'b0, 4'b0010, 1'b0});
        tick(); chk("rl_s2", {3'b0, count, done}, {3'b0, 4'b0100, 1'b0});
        tick(); chk("rl_s3", {3'b0, count, done}, {3'b0, 4'b1000, 1'b1});
        tick();

        // ROT_RIGHT 5 from 1000 wraps past WIDTH
        send(2'b10, 4'b0000, 4'd5);
        repeat (4) tick();
        chk("rr5_not_done", {7'b0, done}, 8'd0);
        tick(); chk("rr5_done", {3'b0, count, done}, {3'b0, 4'b0100, 1'b1});
        tick();

        // N=0: one EXEC cycle, count unchanged
        send(2'b01, 4'b0000, 4'd0);
        tick(); chk("rl0_done", {3'b0, count, done}, {3'b0, 4'b0100, 1'b1});
        tick();

        // ROT_RIGHT 4 on 1011 returns to 1011
        send(2'b00, 4'b1011, 4'd0); tick(); tick();
        send(2'b10, 4'b0000, 4'd4);
        tick(); chk("rr4_s1", {4'b0, count}, 8'b1101);
        tick(); tick();
        chk("rr4_s3", {3'b0, count, done}, {3'b0, 4'b0111, 1'b0});
        tick(); chk("rr4_done", {3'b0, count, done}, {3'b0, 4'b1011, 1'b1});
        tick();

        // CLEAR from 1011
        send(2'b11, 4'b0110, 4'd7);
        tick(); chk("clear_done", {3'b0, count, done}, {3'b0, 4'b0001, 1'b1});
        tick();

        // ROT_LEFT 6 aborted on the 3rd EXEC cycle
        send(2'b01, 4'b0000, 4'd6);
        tick(); tick();
        abort = 1'b1;
        tick();
        chk("abort_done", {2'b0, count, done, aborted}, {2'b0, 4'b0100, 1'b1, 1'b1});
        tick();
        chk("abort_idle", {6'b0, done, aborted}, 8'd0);

        // abort in IDLE is ignored
        tick();
        chk("abort_idle_ign", {2'b0, count, cmd_ready, busy}, {2'b0, 4'b0100, 1'b1, 1'b0});
        abort = 1'b0;

        // Reset mid ROT_RIGHT 10
        send(2'b00, 4'b0001, 4'd0); tick(); tick();
        send(2'b10, 4'b0000, 4'd10);
        tick(); tick();
        chk("rr10_pre_reset", {3'b0, count, busy}, {3'b0, 4'b0100, 1'b1});
        #2 reset = 1'b0;
        #1;
        chk("mid_reset", {2'b0, count, busy, done}, {2'b0, 4'b0001, 1'b0, 1'b0});
        #3 reset = 1'b1;
        tick(); tick();
        chk("post_reset_quiet", {5'b0, done, busy, cmd_ready}, 8'b001);
        send(2'b00, 4'b0011, 4'd0);
        tick(); chk("post_reset_load", {3'b0, count, done}, {3'b0, 4'b0011, 1'b1});
        tick();

        // All-zero LOAD
        send(2'b00, 4'b0000, 4'd0);
        tick();
`ifdef RING_ROTATE_SEQ_ZERO_GUARD_EN
        chk("zero_load", {2'b0, count, done, err}, {2'b0, 4'b0011, 1'b1, 1'b1});
`else
        chk("zero_load", {2'b0, count, done, err}, {2'b0, 4'b0000, 1'b1, 1'b0});
`endif
        tick();
        chk("zero_load_after", {6'b0, done, err}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
